// File: rtl/loong_enc_core.sv
// Iterative LOONG-64 encryption core: 4x4 nibble state, UNROLL rounds per clock, valid/ready on both sides.
// Optional build macro LOONG_TWEAK_EN adds a 64-bit tweak XORed into the key of odd rounds.
module loong_enc_core #(
  parameter int ROUNDS = 16,
  parameter int UNROLL = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] plaintext,
  input  logic [63:0] key,
`ifdef LOONG_TWEAK_EN
  input  logic [63:0] tweak,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] ciphertext,
  output logic        busy
);

  localparam int RW = $clog2(ROUNDS + 1);

  generate
    if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
      $error("loong_enc_core: ROUNDS must be in 1..16");
    end
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
      $error("loong_enc_core: UNROLL must be 1, 2 or 4 and divide ROUNDS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] rc_tab(input int r);
    logic [3:0] c;
    case (r)
      0:  c = 4'h1;  1:  c = 4'h3;  2:  c = 4'h7;  3:  c = 4'hF;
      4:  c = 4'hE;  5:  c = 4'hD;  6:  c = 4'hB;  7:  c = 4'h6;
      8:  c = 4'hC;  9:  c = 4'h9;  10: c = 4'h2;  11: c = 4'h5;
      12: c = 4'hA;  13: c = 4'h4;  14: c = 4'h8;  15: c = 4'h3;
      default: c = 4'h6;
    endcase
    return c;
  endfunction

  // Round constant lives on the diagonal: cell(i,i) = RC_TAB[r] ^ i, all other cells zero.
  function automatic logic [63:0] rc_val(input int r);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      v[63 - 4 * (5 * i) -: 4] = rc_tab(r) ^ 4'(i);
    end
    return v;
  endfunction

  function automatic logic [63:0] sub_cells(input logic [63:0] s);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4 * n +: 4] = sbox(s[4 * n +: 4]);
    end
    return y;
  endfunction

  // Row j-th cell becomes x[j] ^ x[j+1] ^ x[j+2] (mod 4), done as cell rotations of a 16-bit row.
  function automatic logic [63:0] mix_row(input logic [63:0] s);
    logic [63:0] y;
    logic [15:0] r;
    y = '0;
    for (int i = 0; i < 4; i++) begin
      r = s[63 - 16 * i -: 16];
      y[63 - 16 * i -: 16] = r ^ {r[11:0], r[15:12]} ^ {r[7:0], r[15:8]};
    end
    return y;
  endfunction

  // Column i-th cell becomes x[i] ^ x[i+1] ^ x[i+3] (mod 4).
  function automatic logic [63:0] mix_col(input logic [63:0] s);
    logic [63:0] y;
    logic [15:0] c;
    logic [15:0] m;
    y = '0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) begin
        c[15 - 4 * i -: 4] = s[63 - 4 * (4 * i + j) -: 4];
      end
      m = c ^ {c[11:0], c[15:12]} ^ {c[3:0], c[15:4]};
      for (int i = 0; i < 4; i++) begin
        y[63 - 4 * (4 * i + j) -: 4] = m[15 - 4 * i -: 4];
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] loong_round(input logic [63:0] s, input logic [63:0] rk,
                                              input int r);
    return sub_cells(mix_col(mix_row(sub_cells(s)))) ^ rk ^ rc_val(r);
  endfunction

  fsm_e          fsm_q,   fsm_d;
  logic [63:0]   data_q,  data_d;
  logic [63:0]   key_q,   key_d;
  logic [RW-1:0] rnd_q,   rnd_d;
  logic [63:0]   rk_odd;
  logic [63:0]   chain;
  logic          accept;
  int            rn;

`ifdef LOONG_TWEAK_EN
  logic [63:0]   tweak_q, tweak_d;
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no path infers a latch.
  always_comb begin
    fsm_d  = fsm_q;
    data_d = data_q;
    key_d  = key_q;
    rnd_d  = rnd_q;
`ifdef LOONG_TWEAK_EN
    tweak_d = tweak_q;
    rk_odd  = key_q ^ tweak_q;
`else
    rk_odd  = key_q;
`endif

    in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    chain = data_q;
    rn    = 0;
    for (int u = 0; u < UNROLL; u++) begin
      rn    = int'(rnd_q) + u + 1;
      chain = loong_round(chain, rn[0] ? rk_odd : key_q, rn);
    end

    case (fsm_q)
      ROUND: begin
        data_d = chain;
        rnd_d  = rnd_q + RW'(UNROLL);
        if (int'(rnd_q) + UNROLL == ROUNDS) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready && !in_valid) begin
          fsm_d = IDLE;
        end
      end
      default: ;
    endcase

    // A new block may arrive from IDLE or in the same cycle the previous result drains.
    if (accept) begin
      key_d  = key;
      data_d = plaintext ^ key ^ rc_val(0);
      rnd_d  = '0;
      fsm_d  = ROUND;
`ifdef LOONG_TWEAK_EN
      tweak_d = tweak;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q  <= IDLE;
      data_q <= '0;
      key_q  <= '0;
      rnd_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      data_q <= data_d;
      key_q  <= key_d;
      rnd_q  <= rnd_d;
    end
  end

`ifdef LOONG_TWEAK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tweak_q <= '0;
    end else begin
      tweak_q <= tweak_d;
    end
  end
`endif

  assign out_valid  = (fsm_q == DONE);
  assign busy       = (fsm_q == ROUND) || (fsm_q == DONE);
  assign ciphertext = out_valid ? data_q : '0;

endmodule

// File: tb/tb_loong_enc_core.sv
// Bench for loong_enc_core: three configurations (16/1, 16/4, 8/2) share one stimulus stream.
// Expected ciphertexts come from a cell-array reference model of the cipher.
module tb_loong_enc_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] plaintext;
  logic [63:0] key;
  logic [63:0] tweak;
  logic [2:0]  ir, ov, bz;
  logic [63:0] ct [3];

  int errors = 0;
  int checks = 0;

  localparam int NR  [3] = '{16, 16, 8};
  localparam int LAT [3] = '{17, 5, 5};

`ifdef LOONG_TWEAK_EN
  localparam bit TWEAK_EN = 1'b1;
`else
  localparam bit TWEAK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  loong_enc_core #(.ROUNDS(16), .UNROLL(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .plaintext(plaintext), .key(key),
`ifdef LOONG_TWEAK_EN
    .tweak(tweak),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .ciphertext(ct[0]), .busy(bz[0]));

  loong_enc_core #(.ROUNDS(16), .UNROLL(4)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .plaintext(plaintext), .key(key),
`ifdef LOONG_TWEAK_EN
    .tweak(tweak),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .ciphertext(ct[1]), .busy(bz[1]));

  loong_enc_core #(.ROUNDS(8), .UNROLL(2)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
    .plaintext(plaintext), .key(key),
`ifdef LOONG_TWEAK_EN
    .tweak(tweak),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .ciphertext(ct[2]), .busy(bz[2]));

  localparam logic [3:0] SB  [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] RCT [17] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                                      4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h3, 4'h6};

  // Reference model on a 4x4 grid of cells; cell(i,j) sits at bits [63-4*(4i+j) -: 4].
  function automatic logic [63:0] model(input logic [63:0] p, input logic [63:0] k,
                                        input logic [63:0] t_in, input int rounds);
    logic [3:0]  s [4][4];
    logic [3:0]  a [4][4];
    logic [3:0]  b [4][4];
    logic [63:0] t, rk, out;
    t = TWEAK_EN ? t_in : 64'h0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        s[i][j] = p[63 - 4 * (4 * i + j) -: 4] ^ k[63 - 4 * (4 * i + j) -: 4];
    for (int i = 0; i < 4; i++) s[i][i] = s[i][i] ^ RCT[0] ^ 4'(i);
    for (int r = 1; r <= rounds; r++) begin
      rk = (r % 2 == 1) ? (k ^ t) : k;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) a[i][j] = SB[s[i][j]];
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) b[i][j] = a[i][j] ^ a[i][(j + 1) % 4] ^ a[i][(j + 2) % 4];
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) a[i][j] = b[i][j] ^ b[(i + 1) % 4][j] ^ b[(i + 3) % 4][j];
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) s[i][j] = SB[a[i][j]] ^ rk[63 - 4 * (4 * i + j) -: 4];
      for (int i = 0; i < 4; i++) s[i][i] = s[i][i] ^ RCT[r] ^ 4'(i);
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) out[63 - 4 * (4 * i + j) -: 4] = s[i][j];
    return out;
  endfunction

  typedef struct {
    logic [63:0] p;
    logic [63:0] k;
    logic [63:0] t;
    logic [63:0] exp16;
    logic [63:0] exp8;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    plaintext = '0; key = '0; tweak = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents one block in the current cycle (cycle 0) and measures latency/result on all instances.
  task automatic run_measure(input string tag, input logic [63:0] p, input logic [63:0] k,
                             input logic [63:0] t, input logic [63:0] e16, input logic [63:0] e8);
    int lat [3];
    logic [63:0] exp;
    plaintext = p; key = k; tweak = t; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, " in_ready"}, {61'h0, ir}, 64'h7);
    lat = '{0, 0, 0};
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        // Inputs changing after acceptance must not disturb the block in flight.
        in_valid  = 1'b0;
        plaintext = {$urandom, $urandom};
        key       = {$urandom, $urandom};
        tweak     = {$urandom, $urandom};
      end
      for (int i = 0; i < 3; i++)
        if (ov[i] && lat[i] == 0) lat[i] = e;
    end
    for (int i = 0; i < 3; i++) begin
      exp = (NR[i] == 16) ? e16 : e8;
      check($sformatf("%s latency inst%0d", tag, i), 64'(lat[i]), 64'(LAT[i]));
      check($sformatf("%s ciphertext inst%0d", tag, i), ct[i], exp);
    end
  endtask

  logic [63:0] hold_c;
  logic [63:0] blk [3];
  logic [63:0] bexp [3];
  int          acc_cyc [3];
  int          nacc, nout;
  logic        acc, hs;

  initial begin
    vecs[0] = '{p: 64'h0, k: 64'h0, t: 64'h0, exp16: 64'h0, exp8: 64'h0};
    vecs[1] = '{p: 64'h0123456789ABCDEF, k: 64'h0123456789ABCDEF, t: 64'h0, exp16: 64'h0, exp8: 64'h0};
    vecs[2] = '{p: 64'h0123456789ABCDEF, k: 64'hFEDCBA9876543210, t: 64'hFFFF_0000_FFFF_0000,
                exp16: 64'h0, exp8: 64'h0};
    vecs[3] = '{p: 64'hDEADBEEFCAFEF00D, k: 64'h0F1E2D3C4B5A6978, t: 64'h0, exp16: 64'h0, exp8: 64'h0};
    foreach (vecs[n]) begin
      vecs[n].exp16 = model(vecs[n].p, vecs[n].k, vecs[n].t, 16);
      vecs[n].exp8  = model(vecs[n].p, vecs[n].k, vecs[n].t, 8);
    end

    // Reset state.
    do_reset();
    check("reset in_ready", {61'h0, ir}, 64'h7);
    check("reset out_valid", {61'h0, ov}, 64'h0);
    check("reset busy", {61'h0, bz}, 64'h0);
    check("reset ciphertext", ct[0] | ct[1] | ct[2], 64'h0);

    // Table-driven vectors across all three configurations.
    foreach (vecs[n]) begin
      do_reset();
      run_measure($sformatf("vec%0d", n), vecs[n].p, vecs[n].k, vecs[n].t,
                  vecs[n].exp16, vecs[n].exp8);
    end

    // Backpressure: every instance now sits in DONE with out_ready low.
    hold_c = ct[0];
    check("bp initial C", hold_c, vecs[3].exp16);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; plaintext = {$urandom, $urandom}; key = {$urandom, $urandom};
      @(posedge clk); #1;
      check($sformatf("bp C stable c%0d", c), ct[0], hold_c);
      check($sformatf("bp in_ready c%0d", c), {63'h0, ir[0]}, 64'h0);
      check($sformatf("bp out_valid c%0d", c), {63'h0, ov[0]}, 64'h1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp release out_valid", {63'h0, ov[0]}, 64'h0);
    check("bp release in_ready", {63'h0, ir[0]}, 64'h1);
    check("bp release busy", {63'h0, bz[0]}, 64'h0);

    // Back-to-back: three blocks with in_valid held high and out_ready=1.
    blk[0] = 64'h1111_2222_3333_4444;
    blk[1] = 64'hA5A5_5A5A_0F0F_F0F0;
    blk[2] = 64'h0000_0000_0000_0001;
    for (int n = 0; n < 3; n++) bexp[n] = model(blk[n], 64'h0123456789ABCDEF, 64'h0, 16);
    do_reset();
    key = 64'h0123456789ABCDEF; plaintext = blk[0]; in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nout = 0;
    for (int c = 0; c < 100 && nout < 3; c++) begin
      acc = in_valid && ir[0];
      hs  = ov[0] && out_ready;
      if (hs) begin
        check($sformatf("b2b C blk%0d", nout), ct[0], bexp[nout]);
        nout++;
      end
      if (acc) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (nacc < 3) plaintext = blk[nacc];
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b outputs seen", 64'(nout), 64'd3);
    check("b2b accepts", 64'(nacc), 64'd3);
    if (nacc == 3) begin
      check("b2b spacing 0-1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd17);
      check("b2b spacing 1-2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd17);
    end
    out_ready = 1'b0;

    // Reset mid-round (16/1 at round 7) while 16/4 is already holding a result in DONE.
    do_reset();
    plaintext = vecs[1].p; key = vecs[1].k; tweak = vecs[1].t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre-reset busy inst0", {63'h0, bz[0]}, 64'h1);
    check("pre-reset out_valid inst1", {63'h0, ov[1]}, 64'h1);
    reset = 1'b1;
    #1;
    check("async reset out_valid", {61'h0, ov}, 64'h0);
    check("async reset busy", {61'h0, bz}, 64'h0);
    check("async reset ciphertext", ct[0] | ct[1] | ct[2], 64'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_measure("post-reset", vecs[3].p, vecs[3].k, vecs[3].t, vecs[3].exp16, vecs[3].exp8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
